serial_adder_unit: RTL and testbench

//   Bit-serial WIDTH-bit adder/subtractor built around one full_adder instance plus a carry flop.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/full_adder.sv | 17 +
 rtl/serial_adder_unit.sv | 143 ++++++++++++++
 tb/tb_serial_adder_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder/subtractor.
//   serial_adder_state_e : controller states (IDLE -> SHIFT -> DONE -> IDLE)
//   DefaultWidth         : default operand/result width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } serial_adder_state_e;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; the only arithmetic element of the serial adder.
// Ports:
//   a_i, b_i, cin_i : addend bits and carry-in
//   sum_o           : a ^ b ^ cin
//   cout_o          : majority(a, b, cin)
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder_unit.sv
// Bit-serial WIDTH-bit adder/subtractor. One operand pair is accepted over
// valid/ready, processed LSB first at one bit per cycle through a single
// full adder plus carry flop, and returned with its carry-out over valid/ready.
// Ports:
//   clk_i        : clock, all state on rising edge
//   rst_i        : synchronous active-high reset
//   in_valid_i   : operand pair valid
//   in_ready_o   : unit idle and able to accept operands
//   op_a_i       : operand A
//   op_b_i       : operand B
//   cin_i        : carry-in for add; ignored for subtract
//   sub_i        : 1 = A - B, 0 = A + B + cin
//   out_valid_o  : result valid
//   out_ready_i  : downstream accepts result
//   sum_o        : registered result (modulo 2^WIDTH)
//   cout_o       : registered carry-out; for subtract 1 = no borrow
module serial_adder_unit
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  serial_adder_state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Result registers are separate from the shift register so sum_o/cout_o
  // hold the last result through IDLE and the next SHIFT phase.
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_cout_q, res_cout_d;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_shift;

  full_adder u_full_adder (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign sum_shift = {fa_sum, sum_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    res_cout_d  = res_cout_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          a_d     = op_a_i;
          // Subtract as A + ~B + 1; cin_i is deliberately ignored here.
          b_d     = sub_i ? ~op_b_i : op_b_i;
          carry_d = sub_i ? 1'b1 : cin_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sum_d   = sum_shift;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          res_d      = sum_shift;
          res_cout_d = fa_cout;
          state_d    = DONE;
        end
      end

      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      res_q      <= '0;
      res_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      res_cout_q <= res_cout_d;
    end
  end

  assign sum_o  = res_q;
  assign cout_o = res_cout_q;

endmodule

// File: tb/tb_serial_adder_unit.sv
module tb_serial_adder_unit;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int errs;
  int checks;

  serial_adder_unit #(
    .WIDTH (W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .cin_i       (cin),
    .sub_i       (sub),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .cout_o      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents one operand pair for one edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errs++;
      $display("FAIL start_op_ready: in_ready=%0b required 1", in_ready);
    end
    op_a     = a;
    op_b     = b;
    cin      = c;
    sub      = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
    int lat;
    start_op(a, b, c, s);
    wait_valid(lat);
    checks++;
    if (out_valid !== 1'b1) begin
      errs++;
      $display("FAIL %s_valid: out_valid=%b required 1 (timeout)", name, out_valid);
    end
    checks++;
    if (sum !== exp_sum) begin
      errs++;
      $display("FAIL %s_sum: got 0x%02h required 0x%02h", name, sum, exp_sum);
    end
    checks++;
    if (cout !== exp_cout) begin
      errs++;
      $display("FAIL %s_cout: got %b required %b", name, cout, exp_cout);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    checks++;
    if (sum !== 8'h00) begin
      errs++;
      $display("FAIL reset_sum: got 0x%02h required 0x00", sum);
    end
    checks++;
    if (cout !== 1'b0) begin
      errs++;
      $display("FAIL reset_cout: got %b required 0", cout);
    end
  endtask

  task automatic test_add_latency();
    int lat;
    start_op(8'h5A, 8'h33, 1'b0, 1'b0);
    wait_valid(lat);
    // Accept at edge E; DONE is entered at edge E+8 (cycle E+9).
    checks++;
    if (lat !== 8) begin
      errs++;
      $display("FAIL add_latency: got %0d edges required 8", lat);
    end
    checks++;
    if (sum !== 8'h8D) begin
      errs++;
      $display("FAIL add_sum: got 0x%02h required 0x8D", sum);
    end
    checks++;
    if (cout !== 1'b0) begin
      errs++;
      $display("FAIL add_cout: got %b required 0", cout);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL add_return_idle: in_ready=%b out_valid=%b required 1/0", in_ready,
               out_valid);
    end
  endtask

  task automatic test_carry();
    run_op("carry_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op("carry_ff_00_cin", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    run_op("carry_7f_00_cin", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0);
  endtask

  task automatic test_sub();
    run_op("sub_10_01_c0", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op("sub_10_01_c1", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1);
    run_op("sub_00_01_c1", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0);
    run_op("sub_00_01_c0", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0);
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(8'h12, 8'h34, 1'b0, 1'b0);
    wait_valid(lat);
    // Competing operands presented while stalled must be ignored.
    op_a     = 8'hEE;
    op_b     = 8'hEE;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL bp_hs_%0d: out_valid=%b in_ready=%b required 1/0", i, out_valid,
                 in_ready);
      end
      checks++;
      if (sum !== 8'h46 || cout !== 1'b0) begin
        errs++;
        $display("FAIL bp_hold_%0d: sum=0x%02h cout=%b required 0x46/0", i, sum, cout);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    // Result is not cleared on leaving DONE.
    checks++;
    if (sum !== 8'h46) begin
      errs++;
      $display("FAIL bp_sum_persist: got 0x%02h required 0x46", sum);
    end
  endtask

  task automatic test_reset_mid();
    start_op(8'hAA, 8'h55, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_state: in_ready=%b out_valid=%b required 1/0", in_ready,
               out_valid);
    end
    checks++;
    if (sum !== 8'h00 || cout !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_result: sum=0x%02h cout=%b required 0x00/0", sum, cout);
    end
    run_op("rstmid_follow", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic         tc [4];
    logic [W-1:0] ts [4];
    logic         tco[4];
    int n_acc;
    int n_res;
    int cyc;
    int last_acc;
    ta[0] = 8'h3C; tb[0] = 8'hC4; tc[0] = 1'b0; ts[0] = 8'h00; tco[0] = 1'b1;
    ta[1] = 8'h7F; tb[1] = 8'h01; tc[1] = 1'b1; ts[1] = 8'h81; tco[1] = 1'b0;
    ta[2] = 8'hA5; tb[2] = 8'h5A; tc[2] = 1'b1; ts[2] = 8'h00; tco[2] = 1'b1;
    ta[3] = 8'h64; tb[3] = 8'h23; tc[3] = 1'b0; ts[3] = 8'h87; tco[3] = 1'b0;
    n_acc     = 0;
    n_res     = 0;
    cyc       = 0;
    last_acc  = 0;
    sub       = 1'b0;
    out_ready = 1'b1;
    while (n_res < 4 && cyc < 100) begin
      if (n_acc < 4) begin
        op_a     = ta[n_acc];
        op_b     = tb[n_acc];
        cin      = tc[n_acc];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (in_ready && in_valid) begin
        if (n_acc > 0) begin
          checks++;
          if (cyc - last_acc != 10) begin
            errs++;
            $display("FAIL b2b_interval_%0d: got %0d cycles required 10", n_acc,
                     cyc - last_acc);
          end
        end
        last_acc = cyc;
        n_acc++;
      end
      if (out_valid) begin
        checks++;
        if (sum !== ts[n_res] || cout !== tco[n_res]) begin
          errs++;
          $display("FAIL b2b_result_%0d: sum=0x%02h cout=%b required 0x%02h/%b", n_res, sum,
                   cout, ts[n_res], tco[n_res]);
        end
        n_res++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (n_res != 4) begin
      errs++;
      $display("FAIL b2b_timeout: got %0d results required 4", n_res);
    end
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    test_reset();
    test_add_latency();
    test_carry();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
